// File: rtl/y_loader.sv
// Program loader and run sequencer for yChip: assembles a little-endian byte stream into
// instruction words, writes them from a header entry point, then boots and times the CPU.
module y_loader #(
   parameter int unsigned MAX_WORDS  = 256,
   parameter int unsigned RUN_CYCLES = 43,
   parameter int unsigned CNT_W      = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  inByte,
   input  logic        inValid,
   output logic        inReady,
   output logic [31:0] memAddr,
   output logic [31:0] memWrData,
   output logic        memWrEn,
   output logic [31:0] entryPoint,
   output logic        INT,
   output logic        cpuEn,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      StHdrEntry,
      StHdrCount,
      StLoad,
      StDrain,
      StStart,
      StRun,
      StDone,
      StErr
   } state_e;

   state_e             state_q, state_d;
   logic [1:0]         byte_cnt_q;
   logic [23:0]        shift_q;
   logic [31:0]        entry_q;
   logic [31:0]        addr_q;
   logic [31:0]        data_q;
   logic               wr_en_q;
   logic [CNT_W-1:0]   n_q;
   logic [CNT_W-1:0]   word_q;
   logic [CNT_W-1:0]   run_q;

   logic               xfer;
   logic               last_byte;
   logic [31:0]        full_word;

   // Gated by rst_n so the loader never advertises readiness while held in reset.
   assign inReady   = rst_n && (state_q == StHdrEntry || state_q == StHdrCount ||
                                state_q == StLoad);
   assign xfer      = inValid && inReady;
   assign last_byte = (byte_cnt_q == 2'd3);
   assign full_word = {inByte, shift_q};

   always_comb begin
      state_d = state_q;
      case (state_q)
         StHdrEntry: if (xfer && last_byte) state_d = StHdrCount;
         StHdrCount: begin
            if (xfer && last_byte) begin
               if (full_word > MAX_WORDS) state_d = StErr;
               else if (full_word == '0) state_d = StStart;
               else state_d = StLoad;
            end
         end
         StLoad: if (xfer && last_byte && word_q == n_q - CNT_W'(1)) state_d = StDrain;
         StDrain:    state_d = StStart;
         StStart:    state_d = StRun;
         StRun:      if (run_q == CNT_W'(RUN_CYCLES - 1)) state_d = StDone;
         StDone:     state_d = StHdrEntry;
         StErr:      state_d = StErr;
         default:    state_d = StErr;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StHdrEntry;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         entry_q    <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         wr_en_q    <= 1'b0;
         n_q        <= '0;
         word_q     <= '0;
         run_q      <= '0;
      end else begin
         state_q <= state_d;
         wr_en_q <= 1'b0;
         if (xfer) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            shift_q    <= {inByte, shift_q[23:8]};
         end
         if (xfer && last_byte) begin
            case (state_q)
               StHdrEntry: entry_q <= full_word;
               StHdrCount: begin
                  n_q    <= full_word[CNT_W-1:0];
                  word_q <= '0;
               end
               StLoad: begin
                  wr_en_q <= 1'b1;
                  data_q  <= full_word;
                  addr_q  <= entry_q + (32'(word_q) << 2);
                  word_q  <= word_q + CNT_W'(1);
               end
               default: ;
            endcase
         end
         if (state_q == StStart) run_q <= '0;
         else if (state_q == StRun) run_q <= run_q + CNT_W'(1);
      end
   end

   assign memAddr    = addr_q;
   assign memWrData  = data_q;
   assign memWrEn    = wr_en_q;
   assign entryPoint = entry_q;
   assign INT        = (state_q == StStart);
   assign cpuEn      = (state_q == StRun);
   assign done       = (state_q == StDone);
   assign err        = (state_q == StErr);
   assign busy       = !(state_q == StHdrEntry || state_q == StErr);

endmodule
